// File: rtl/reg_file_master.sv
// Command-side initiator: decodes UART write/read frames into register-file
// cycles and forwards read results to the UART transmitter.
module reg_file_master #(
  parameter int unsigned         DATA_WIDTH = 8,
  parameter int unsigned         ADDR_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0] WR_CMD   = 8'hAA,
  parameter logic [DATA_WIDTH-1:0] RD_CMD   = 8'hBB,
  parameter int unsigned         RD_TIMEOUT = 15
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_P_Data,
  input  logic                  RX_D_VLD,
  input  logic [DATA_WIDTH-1:0] RdData,
  input  logic                  RdData_Valid,
  input  logic                  TX_Busy,
  output logic                  WrEn,
  output logic                  RdEn,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic [DATA_WIDTH-1:0] WrData,
  output logic [DATA_WIDTH-1:0] TX_P_Data,
  output logic                  TX_D_VLD,
  output logic                  Cmd_Err
);

  localparam int unsigned CNT_W = $clog2(RD_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(RD_TIMEOUT);

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_WAIT,
    TX_REQ
  } state_e;

  state_e                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [DATA_WIDTH-1:0] txBuf_q;
  logic                  wrEn_q;
  logic                  rdEn_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wrData_q;
  logic [DATA_WIDTH-1:0] txData_q;
  logic                  txVld_q;
  logic                  cmdErr_q;

  // Strobe outputs default low every cycle so each is a single-cycle pulse;
  // Address/WrData/TX_P_Data simply hold until the next frame overwrites them.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      txBuf_q  <= '0;
      wrEn_q   <= 1'b0;
      rdEn_q   <= 1'b0;
      addr_q   <= '0;
      wrData_q <= '0;
      txData_q <= '0;
      txVld_q  <= 1'b0;
      cmdErr_q <= 1'b0;
    end else begin
      wrEn_q   <= 1'b0;
      rdEn_q   <= 1'b0;
      txVld_q  <= 1'b0;
      cmdErr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (RX_D_VLD) begin
            if (RX_P_Data == WR_CMD) begin
              state_q <= WR_ADDR;
            end else if (RX_P_Data == RD_CMD) begin
              state_q <= RD_ADDR;
            end else begin
              cmdErr_q <= 1'b1;
            end
          end
        end
        WR_ADDR: begin
          if (RX_D_VLD) begin
            addr_q  <= RX_P_Data[ADDR_WIDTH-1:0];
            state_q <= WR_DATA;
          end
        end
        WR_DATA: begin
          if (RX_D_VLD) begin
            wrData_q <= RX_P_Data;
            wrEn_q   <= 1'b1;
            state_q  <= IDLE;
          end
        end
        RD_ADDR: begin
          if (RX_D_VLD) begin
            addr_q  <= RX_P_Data[ADDR_WIDTH-1:0];
            rdEn_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= RD_WAIT;
          end
        end
        // Valid data wins over a timeout landing on the same edge.
        RD_WAIT: begin
          if (RdData_Valid) begin
            txBuf_q <= RdData;
            state_q <= TX_REQ;
          end else if (cnt_q + 1'b1 == TIMEOUT_CNT) begin
            cmdErr_q <= 1'b1;
            state_q  <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        TX_REQ: begin
          if (!TX_Busy) begin
            txData_q <= txBuf_q;
            txVld_q  <= 1'b1;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign WrEn      = wrEn_q;
  assign RdEn      = rdEn_q;
  assign Address   = addr_q;
  assign WrData    = wrData_q;
  assign TX_P_Data = txData_q;
  assign TX_D_VLD  = txVld_q;
  assign Cmd_Err   = cmdErr_q;

endmodule

// File: tb/tb_reg_file_master.sv
// Directed bench for reg_file_master with a behavioural 16x8 register file
// that answers RdEn one cycle later with RdData_Valid.
module tb_reg_file_master;

  logic       CLK;
  logic       RST;
  logic [7:0] RX_P_Data;
  logic       RX_D_VLD;
  logic [7:0] RdData;
  logic       RdData_Valid;
  logic       TX_Busy;
  logic       WrEn;
  logic       RdEn;
  logic [3:0] Address;
  logic [7:0] WrData;
  logic [7:0] TX_P_Data;
  logic       TX_D_VLD;
  logic       Cmd_Err;

  logic [7:0] mem [16];
  logic       rfClear;
  logic       rfMute;

  int checkCount = 0;
  int errorCount = 0;
  int wrCount = 0;
  int rdCount = 0;
  int errPulses = 0;
  int txCount = 0;
  int bothEn = 0;
  int errTx = 0;
  int baseWr, baseRd, baseErr, baseTx, cyc;

  reg_file_master dut (
    .CLK(CLK),
    .RST(RST),
    .RX_P_Data(RX_P_Data),
    .RX_D_VLD(RX_D_VLD),
    .RdData(RdData),
    .RdData_Valid(RdData_Valid),
    .TX_Busy(TX_Busy),
    .WrEn(WrEn),
    .RdEn(RdEn),
    .Address(Address),
    .WrData(WrData),
    .TX_P_Data(TX_P_Data),
    .TX_D_VLD(TX_D_VLD),
    .Cmd_Err(Cmd_Err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Register file model: write at the edge closing the WrEn cycle, read data
  // valid for one cycle after RdEn; rfMute suppresses the valid strobe.
  always @(posedge CLK) begin
    if (rfClear) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
      RdData       <= 8'h00;
      RdData_Valid <= 1'b0;
    end else begin
      if (WrEn) mem[Address] <= WrData;
      if (RdEn) RdData <= mem[Address];
      RdData_Valid <= RdEn && !rfMute;
    end
  end

  // Per-cycle pulse counters, sampled before the edge updates the outputs.
  always @(posedge CLK) begin
    if (WrEn === 1'b1) wrCount++;
    if (RdEn === 1'b1) rdCount++;
    if (Cmd_Err === 1'b1) errPulses++;
    if (TX_D_VLD === 1'b1) txCount++;
    if (WrEn === 1'b1 && RdEn === 1'b1) bothEn++;
    if (Cmd_Err === 1'b1 && TX_D_VLD === 1'b1) errTx++;
  end

  task automatic applyStimulus(input logic [7:0] b);
    @(negedge CLK);
    RX_P_Data = b;
    RX_D_VLD  = 1'b1;
    @(negedge CLK);
    RX_D_VLD  = 1'b0;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge CLK);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected)
    else begin
      errorCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_outs"},
                {8'h00, 4'h0, WrEn, RdEn, TX_D_VLD, Cmd_Err, Address, WrData, TX_P_Data},
                32'h0);
  endtask

  initial begin
    RST = 1'b0; RX_P_Data = 8'h00; RX_D_VLD = 1'b0; TX_Busy = 1'b0;
    rfClear = 1'b1; rfMute = 1'b0;
    tick(3);
    checkAllZero("reset");
    rfClear = 1'b0;
    RST = 1'b1;

    $display("[TB] test 1: write 3C to address 5");
    baseWr = wrCount;
    applyStimulus(8'hAA);
    applyStimulus(8'h05);
    checkOutput("t1_wren_early", 32'(WrEn), 32'd0);
    applyStimulus(8'h3C);
    checkOutput("t1_wren", 32'(WrEn), 32'd1);
    checkOutput("t1_addr", 32'(Address), 32'h5);
    checkOutput("t1_wrdata", 32'(WrData), 32'h3C);
    tick(1);
    checkOutput("t1_wren_drop", 32'(WrEn), 32'd0);
    checkOutput("t1_wr_pulses", 32'(wrCount - baseWr), 32'd1);
    checkOutput("t1_mem5", 32'(mem[5]), 32'h3C);

    $display("[TB] test 2: read address 5");
    baseRd = rdCount; baseTx = txCount;
    applyStimulus(8'hBB);
    applyStimulus(8'h05);
    checkOutput("t2_rden", 32'(RdEn), 32'd1);
    checkOutput("t2_addr", 32'(Address), 32'h5);
    tick(1);
    checkOutput("t2_rden_drop", 32'(RdEn), 32'd0);
    tick(1);
    checkOutput("t2_txvld_early", 32'(TX_D_VLD), 32'd0);
    tick(1);
    checkOutput("t2_txvld", 32'(TX_D_VLD), 32'd1);
    checkOutput("t2_txdata", 32'(TX_P_Data), 32'h3C);
    tick(1);
    checkOutput("t2_txvld_drop", 32'(TX_D_VLD), 32'd0);
    checkOutput("t2_tx_pulses", 32'(txCount - baseTx), 32'd1);
    checkOutput("t2_rd_pulses", 32'(rdCount - baseRd), 32'd1);

    $display("[TB] test 3: bad opcode then write FF to address 15");
    baseErr = errPulses; baseWr = wrCount; baseRd = rdCount;
    applyStimulus(8'h12);
    checkOutput("t3_cmderr", 32'(Cmd_Err), 32'd1);
    tick(1);
    checkOutput("t3_cmderr_drop", 32'(Cmd_Err), 32'd0);
    checkOutput("t3_no_en", 32'(wrCount - baseWr + rdCount - baseRd), 32'd0);
    applyStimulus(8'hAA);
    applyStimulus(8'h0F);
    applyStimulus(8'hFF);
    checkOutput("t3_wren", 32'(WrEn), 32'd1);
    checkOutput("t3_addr", 32'(Address), 32'hF);
    tick(1);
    checkOutput("t3_mem15", 32'(mem[15]), 32'hFF);
    checkOutput("t3_err_pulses", 32'(errPulses - baseErr), 32'd1);

    $display("[TB] test 4: read timeout");
    rfMute = 1'b1;
    baseTx = txCount; baseErr = errPulses;
    applyStimulus(8'hBB);
    applyStimulus(8'h03);
    cyc = 0;
    while (Cmd_Err !== 1'b1 && cyc < 40) begin
      @(negedge CLK);
      cyc++;
    end
    checkOutput("t4_timeout_cycles", 32'(cyc), 32'd15);
    tick(1);
    checkOutput("t4_cmderr_drop", 32'(Cmd_Err), 32'd0);
    checkOutput("t4_no_tx", 32'(txCount - baseTx), 32'd0);
    checkOutput("t4_err_pulses", 32'(errPulses - baseErr), 32'd1);
    rfMute = 1'b0;
    applyStimulus(8'h55);
    checkOutput("t4_back_idle", 32'(Cmd_Err), 32'd1);

    $display("[TB] test 5: read with transmitter busy");
    applyStimulus(8'hAA);
    applyStimulus(8'h01);
    applyStimulus(8'hA5);
    tick(1);
    checkOutput("t5_mem1", 32'(mem[1]), 32'hA5);
    baseTx = txCount; baseWr = wrCount;
    TX_Busy = 1'b1;
    applyStimulus(8'hBB);
    applyStimulus(8'h31);
    checkOutput("t5_addr_trunc", 32'(Address), 32'h1);
    tick(3);
    applyStimulus(8'hAA);
    tick(13);
    checkOutput("t5_txvld_busy", 32'(TX_D_VLD), 32'd0);
    checkOutput("t5_no_tx_busy", 32'(txCount - baseTx), 32'd0);
    TX_Busy = 1'b0;
    @(negedge CLK);
    checkOutput("t5_txvld", 32'(TX_D_VLD), 32'd1);
    checkOutput("t5_txdata", 32'(TX_P_Data), 32'hA5);
    tick(1);
    checkOutput("t5_txvld_drop", 32'(TX_D_VLD), 32'd0);
    applyStimulus(8'h12);
    checkOutput("t5_extra_dropped", 32'(Cmd_Err), 32'd1);
    checkOutput("t5_no_wr", 32'(wrCount - baseWr), 32'd0);

    $display("[TB] test 6: reset mid-frame");
    baseWr = wrCount;
    applyStimulus(8'hAA);
    applyStimulus(8'h07);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    checkAllZero("t6_reset");
    applyStimulus(8'h3C);
    checkOutput("t6_cmderr", 32'(Cmd_Err), 32'd1);
    checkOutput("t6_wren", 32'(WrEn), 32'd0);
    tick(2);
    checkOutput("t6_no_wr", 32'(wrCount - baseWr), 32'd0);
    checkOutput("t6_mem7", 32'(mem[7]), 32'h00);
    applyStimulus(8'hBB);
    applyStimulus(8'h07);
    tick(3);
    checkOutput("t6_rd7_vld", 32'(TX_D_VLD), 32'd1);
    checkOutput("t6_rd7_data", 32'(TX_P_Data), 32'h00);
    tick(1);

    checkOutput("en_overlap", 32'(bothEn), 32'd0);
    checkOutput("err_tx_overlap", 32'(errTx), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
